axis_register: RTL and testbench
================================

// Module: axis_register
// PURPOSE
//  AXI4-Stream register slice (full-throughput skid buffer) for 8-bit fixed-point samples.
//  Breaks the combinational valid/ready path between an upstream sample source and a downstream sink.
//  Accepts one beat per cycle and adds exactly one cycle of latency.
//  Payload {data, tdata flag, tlast} passes through unmodified.
// PARAMETERS
//  data_width  8  sample width in bits (two's-complement fixed point)
//  int_width   2  integer bits of the sample format (documentation/elaboration check only)
//  frac_width  6  fractional bits; elaboration must fail if int_width+frac_width != data_width
// PORTS
//  clk         in   1           single clock, rising edge
//  reset       in   1           asynchronous, active-high reset
//  data_in     in   data_width  upstream sample
//  tdata_in    in   1           upstream 1-bit sideband flag, carried with the sample
//  tlast_in    in   1           upstream end-of-packet marker
//  tvalid_in   in   1           upstream beat valid
//  tready_out  out  1           ready to upstream (registered)
//  data_out    out  data_width  downstream sample (registered)
//  tdata_out   out  1           downstream sideband flag
//  tlast_out   out  1           downstream end-of-packet marker
//  tvalid_out  out  1           downstream beat valid (registered)
//  tready_in   in   1           downstream ready
// BEHAVIOUR
//  - Reset (async assert, sync release): tvalid_out=0, data_out=0, tdata_out=0, tlast_out=0,
//    skid slot empty, tready_out=1. Mid-stream reset discards all held beats.
//  - Accept: a beat is taken on a rising edge with tvalid_in && tready_out.
//    Emit: a beat completes on a rising edge with tvalid_out && tready_in.
//  - Storage: main register (drives outputs) plus one skid register. tready_out = !skid_valid, registered.
//  - Main register empty, or draining this cycle:
//    - An accepted beat goes to main; valid out on the next cycle (latency 1).
//    - If the skid slot is full, the skid contents move to main first, preserving order.
//  - Main register full and tready_in=0: an accepted beat goes to skid. tready_out drops next cycle.
//  - While tvalid_out=1 and tready_in=0, data_out, tdata_out and tlast_out must hold stable.
//  - Steady state with tready_in=1: one beat per cycle in and out, and tready_out stays 1.
//  - Simultaneous accept and emit with the skid slot empty: main reloads with the new beat, with no bubble.
//  - tvalid_in=0: no state change on the input side. Main drains normally.
//  - tlast and tdata travel in lockstep with their sample. No packet counting or reordering.
//  - Never drop or duplicate a beat. Capacity is 2 beats.
// STRUCTURE
//  - Package axis_register_pkg:
//    - localparam PAYLOAD_W = data_width+2
//    - payload packing order {data, tdata, tlast}
//  - One natural sub-module: axis_skid_slot, a payload register with a valid bit and load/clear enables.
//    Instantiate it twice (main and skid). The top holds the steering logic.
// TESTING
//  1. Reset held 10 ns, then released -> tvalid_out=0, data_out=0, tlast_out=0, tready_out=1.
//  2. tready_in=1, tvalid_in=1, samples 0x00,0x01,...,0x3F on consecutive edges
//     -> each sample appears on data_out one cycle later; tready_out stays 1; no gaps.
//  3. tlast_in=1 only with sample index 10 (0x0A)
//     -> tlast_out=1 only in the cycle data_out=0x0A.
//  4. Send 0x40, 0x41 with tready_in=0
//     -> data_out holds 0x40, tready_out=0 after the 2nd beat.
//     Raise tready_in -> 0x40 then 0x41 emitted, tready_out returns to 1.
//  5. tvalid_in toggled 1/0 every cycle with random tready_in
//     -> output sequence equals input sequence exactly, with matching tdata_out flags.
//  6. Assert reset with both slots full
//     -> outputs clear immediately; after release only newly sent beats appear.

Source files
------------

// File: rtl/axis_register_pkg.sv
// Shared constants and steering types for the axis_register slice.
// Payload packing order is {data, tdata, tlast}.
package axis_register_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int INT_WIDTH  = 2;
   localparam int FRAC_WIDTH = 6;
   localparam int SIDEBAND_W = 2;
   localparam int PAYLOAD_W  = DATA_WIDTH + SIDEBAND_W;

   typedef enum logic [1:0] {
      MAIN_HOLD,
      MAIN_FROM_IN,
      MAIN_FROM_SKID,
      MAIN_DRAIN
   } main_sel_e;

endpackage

// File: rtl/axis_skid_slot.sv
// One beat of storage: a payload register plus its valid bit.
// load has priority over clear; clear only drops valid, the payload is left as is.
module axis_skid_slot #(
   parameter int width = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             clear,
   input  logic [width-1:0] payload_in,
   output logic             valid_out,
   output logic [width-1:0] payload_out
);

   logic             valid_d, valid_q;
   logic [width-1:0] payload_d, payload_q;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      valid_d   = valid_q;
      payload_d = payload_q;
      if (load) begin
         valid_d   = 1'b1;
         payload_d = payload_in;
      end else if (clear) begin
         valid_d   = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the payload is reset as well as valid, because the main slot drives data_out, which must read 0 out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
      end
   end

   assign valid_out   = valid_q;
   assign payload_out = payload_q;

endmodule

// File: rtl/axis_register.sv
// AXI4-Stream register slice: a main slot drives the outputs, a skid slot absorbs the
// one beat accepted while downstream stalls, so both valid and ready leave from flops.
module axis_register
   import axis_register_pkg::*;
#(
   parameter int data_width = DATA_WIDTH,
   parameter int int_width  = INT_WIDTH,
   parameter int frac_width = FRAC_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [data_width-1:0] data_in,
   input  logic                  tdata_in,
   input  logic                  tlast_in,
   input  logic                  tvalid_in,
   output logic                  tready_out,
   output logic [data_width-1:0] data_out,
   output logic                  tdata_out,
   output logic                  tlast_out,
   output logic                  tvalid_out,
   input  logic                  tready_in
);

   localparam int payload_w = data_width + SIDEBAND_W;

   if (int_width + frac_width != data_width) begin : g_bad_format
      $error("axis_register: int_width + frac_width must equal data_width");
   end

   logic                 main_valid, skid_valid;
   logic [payload_w-1:0] in_payload, main_payload, skid_payload, main_next;
   logic                 main_load, main_clear, skid_load, skid_clear;
   logic                 accept;
   main_sel_e            main_sel;

   assign in_payload = {data_in, tdata_in, tlast_in};
   assign tready_out = !skid_valid;
   assign accept     = tvalid_in && tready_out;

   // The main slot may take a new beat whenever it is empty or draining this cycle;
   // a full skid always goes first so beats leave in arrival order.
   always_comb begin
      main_sel   = MAIN_HOLD;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (!main_valid || tready_in) begin
         if (skid_valid) begin
            main_sel   = MAIN_FROM_SKID;
            skid_clear = 1'b1;
         end else if (accept) begin
            main_sel   = MAIN_FROM_IN;
         end else if (main_valid) begin
            main_sel   = MAIN_DRAIN;
         end
      end else if (accept) begin
         skid_load = 1'b1;
      end
   end

   assign main_load  = (main_sel == MAIN_FROM_IN) || (main_sel == MAIN_FROM_SKID);
   assign main_clear = (main_sel == MAIN_DRAIN);
   assign main_next  = (main_sel == MAIN_FROM_SKID) ? skid_payload : in_payload;

   axis_skid_slot #(.width(payload_w)) u_main (
      .clk         (clk),
      .reset       (reset),
      .load        (main_load),
      .clear       (main_clear),
      .payload_in  (main_next),
      .valid_out   (main_valid),
      .payload_out (main_payload)
   );

   axis_skid_slot #(.width(payload_w)) u_skid (
      .clk         (clk),
      .reset       (reset),
      .load        (skid_load),
      .clear       (skid_clear),
      .payload_in  (in_payload),
      .valid_out   (skid_valid),
      .payload_out (skid_payload)
   );

   assign tvalid_out = main_valid;
   assign data_out   = main_payload[payload_w-1:SIDEBAND_W];
   assign tdata_out  = main_payload[1];
   assign tlast_out  = main_payload[0];

endmodule

// File: tb/tb_axis_register.sv
// Self-checking bench for axis_register: a negedge monitor scoreboards every accepted
// beat against every emitted beat, while directed steps and a vector table check timing.
module tb_axis_register;
   import axis_register_pkg::*;

   typedef logic [PAYLOAD_W-1:0] payload_t;

   typedef struct {
      logic       tv_in;
      logic       tr_in;
      logic [7:0] din;
      logic       td_in;
      logic       tl_in;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_tlast;
      logic       exp_tready;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in = '0;
   logic       tdata_in = 1'b0;
   logic       tlast_in = 1'b0;
   logic       tvalid_in = 1'b0;
   logic       tready_out;
   logic [7:0] data_out;
   logic       tdata_out;
   logic       tlast_out;
   logic       tvalid_out;
   logic       tready_in = 1'b0;

   int errors = 0;
   int checks = 0;

   payload_t sb[$];
   logic     prev_stall = 1'b0;
   payload_t prev_payload = '0;

   always #5 clk = ~clk;

   axis_register dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .tdata_in   (tdata_in),
      .tlast_in   (tlast_in),
      .tvalid_in  (tvalid_in),
      .tready_out (tready_out),
      .data_out   (data_out),
      .tdata_out  (tdata_out),
      .tlast_out  (tlast_out),
      .tvalid_out (tvalid_out),
      .tready_in  (tready_in)
   );

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic drive(input logic v, input logic r, input logic [7:0] d, input logic td, input logic tl);
      tvalid_in = v;
      tready_in = r;
      data_in   = d;
      tdata_in  = td;
      tlast_in  = tl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard and stall-stability monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            check("stall_hold", 32'({data_out, tdata_out, tlast_out}), 32'(prev_payload));
         if (tvalid_out && tready_in) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_extra_beat: got 0x%0h, expected no beat at %0t",
                        {data_out, tdata_out, tlast_out}, $time);
            end else begin
               check("sb_beat", 32'({data_out, tdata_out, tlast_out}), 32'(sb.pop_front()));
            end
         end
         if (tvalid_in && tready_out)
            sb.push_back({data_in, tdata_in, tlast_in});
         prev_stall   = tvalid_out && !tready_in;
         prev_payload = {data_out, tdata_out, tlast_out};
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[10];
      int   drain;

      // Stall, skid fill, ordered release, then reload with no bubble.
      vecs[0] = '{1'b1, 1'b0, 8'h40, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 1'b1};
      vecs[1] = '{1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 1'b1, 8'h40, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 8'h42, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 8'h43, 1'b0, 1'b1, 1'b1, 8'h43, 1'b1, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b1, 8'h43, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1};
      vecs[8] = '{1'b1, 1'b1, 8'h45, 1'b0, 1'b0, 1'b1, 8'h45, 1'b0, 1'b1};
      vecs[9] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

      // Reset state
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_tvalid_out", 32'(tvalid_out), 32'd0);
      check("rst_data_out",   32'(data_out),   32'd0);
      check("rst_tdata_out",  32'(tdata_out),  32'd0);
      check("rst_tlast_out",  32'(tlast_out),  32'd0);
      check("rst_tready_out", 32'(tready_out), 32'd1);

      // Full-rate stream with a single tlast at index 10
      for (int i = 0; i < 64; i++) begin
         drive(1'b1, 1'b1, 8'(i), i[0], (i == 10));
         tick();
         check("stream_valid",  32'(tvalid_out), 32'd1);
         check("stream_data",   32'(data_out),   32'(i));
         check("stream_tdata",  32'(tdata_out),  32'(i[0]));
         check("stream_tlast",  32'(tlast_out),  32'(i == 10));
         check("stream_tready", 32'(tready_out), 32'd1);
      end
      drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      tick();
      check("stream_idle_valid", 32'(tvalid_out), 32'd0);

      // Vector table: backpressure corner cases
      for (int v = 0; v < 10; v++) begin
         drive(vecs[v].tv_in, vecs[v].tr_in, vecs[v].din, vecs[v].td_in, vecs[v].tl_in);
         tick();
         check("vec_valid",  32'(tvalid_out), 32'(vecs[v].exp_valid));
         check("vec_tready", 32'(tready_out), 32'(vecs[v].exp_tready));
         if (vecs[v].exp_valid) begin
            check("vec_data",  32'(data_out),  32'(vecs[v].exp_data));
            check("vec_tlast", 32'(tlast_out), 32'(vecs[v].exp_tlast));
         end
      end

      // Toggling valid with random downstream ready; scoreboard checks order and flags
      for (int c = 0; c < 60; c++) begin
         drive((c % 2) == 0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), 1'($urandom));
         tick();
      end
      drain = 0;
      drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      while ((sb.size() != 0 || tvalid_out) && drain < 20) begin
         tick();
         drain++;
      end
      check("random_drain_empty", 32'(sb.size()), 32'd0);
      check("random_drain_valid", 32'(tvalid_out), 32'd0);

      // Reset with both slots full
      drive(1'b1, 1'b0, 8'h60, 1'b1, 1'b0);
      tick();
      drive(1'b1, 1'b0, 8'h61, 1'b0, 1'b1);
      tick();
      check("full_tready", 32'(tready_out), 32'd0);
      check("full_valid",  32'(tvalid_out), 32'd1);
      check("full_data",   32'(data_out),   32'h60);
      #2 reset = 1'b1;
      #1;
      check("midrst_tvalid_out", 32'(tvalid_out), 32'd0);
      check("midrst_data_out",   32'(data_out),   32'd0);
      check("midrst_tdata_out",  32'(tdata_out),  32'd0);
      check("midrst_tlast_out",  32'(tlast_out),  32'd0);
      check("midrst_tready_out", 32'(tready_out), 32'd1);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      drive(1'b1, 1'b1, 8'h70, 1'b0, 1'b0);
      tick();
      check("post_rst_data0",  32'(data_out),   32'h70);
      check("post_rst_valid0", 32'(tvalid_out), 32'd1);
      drive(1'b1, 1'b1, 8'h71, 1'b1, 1'b1);
      tick();
      check("post_rst_data1",  32'(data_out),   32'h71);
      check("post_rst_tlast1", 32'(tlast_out),  32'd1);
      drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      tick();
      check("post_rst_idle",   32'(tvalid_out), 32'd0);
      @(negedge clk);
      check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
